uart_fifo_wb: RTL and testbench
===============================

// Module: uart_fifo_wb
// PURPOSE
//  Self-contained Wishbone UART for the user area: parametrised data width, TX/RX FIFOs, programmable
//  16x-oversampled baud divisor, optional parity, 1/2 stop bits, loopback, sticky error flags, maskable level IRQ.
//  Sits directly on the caravel Wishbone slave bus; drives one TX pad and samples one RX pad.
// PARAMETERS
//  DATA_BITS     8      frame data bits, 5..9
//  TX_DEPTH      16     TX FIFO entries, power of 2, 2..128
//  RX_DEPTH      16     RX FIFO entries, power of 2, 2..128
//  BAUD_DIV_RST  16'd0  BAUD register reset value
// PORTS
//  wb_clk_i   in   1   single clock for all logic
//  wb_rst_ni  in   1   synchronous reset, active-low
//  wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1   Wishbone strobe/cycle/write
//  wbs_sel_i  in   4   byte lanes
//  wbs_dat_i  in   32  write data
//  wbs_adr_i  in   32  address; only [4:2] decoded
//  wbs_ack_o  out  1   one-cycle ack
//  wbs_dat_o  out  32  read data, valid with ack
//  uart_rx    in   1   serial in (asynchronous)
//  uart_tx    out  1   serial out, idle high
//  io_oeb     out  2   constant 2'b01 ([0] rx input, [1] tx output)
//  uart_irq   out  1   level interrupt
// BEHAVIOUR
//  Reset: uart_tx=1, wbs_ack_o=0, wbs_dat_o=0, uart_irq=0, FIFOs empty, CTRL=0, IM=0, sticky flags 0, FSMs IDLE.
//  Bus: stb&cyc&!ack -> ack next cycle for exactly 1 cycle; side effects occur on the ack cycle only.
//   dat_o registered; 0 when not acking. Unmapped reads return 0; unmapped writes are ignored.
//  Map (adr[4:2]): 0 DATA: wr sel[0] pushes dat_i[DATA_BITS-1:0] to TX FIFO (full -> dropped, TX_OVF set);
//   rd pops RX FIFO (empty -> returns 0, no pop).
//   1 STATUS rd: [0]tx_empty [1]tx_full [2]rx_empty [3]rx_full [4]RX_OVR [5]FRAME [6]PAR [7]TX_OVF
//   [8]tx_busy [9]rx_busy [23:16]rx_level [31:24]tx_level; wr: 1s in [7:4] clear those stickies.
//   2 CTRL [0]en [1]tx_en [2]rx_en [3]par_en [4]par_odd [5]stop2 [6]loopback. 3 BAUD [15:0]div.
//   4 IM [2:0]. 5 IRQ rd: [0]!rx_empty [1]tx_empty [2]|sticky[7:4]; unmasked.
//   CTRL/BAUD/IM writes honour wbs_sel_i per byte.
//  uart_irq = |(IM & IRQ), registered (1-cycle lag).
//  Baud: tick when counter==div, then counter->0; one bit = 16 ticks = 16*(div+1) cycles.
//   Counter held at 0 while en=0.
//  TX FSM IDLE->START->DATA(LSB first, DATA_BITS)->[PARITY]->STOP1->[STOP2]->IDLE.
//   Leaves IDLE when en&tx_en&!tx_empty, popping the FIFO that cycle.
//   Parity = ^data (even) or ~^data (odd). tx_busy = !IDLE.
//   tx_en cleared mid-frame: frame completes, no new pop. en cleared: abort at once, uart_tx=1.
//  RX: 2-flop synchroniser. IDLE on falling edge -> START.
//   Re-sample at tick 8: low -> DATA, else back to IDLE (glitch).
//   Each bit sampled at its tick 8. STOP=0 -> FRAME set, word discarded. Parity mismatch -> PAR set, discarded.
//   Good word with RX FIFO full -> dropped, RX_OVR set. rx_en or en cleared -> abort at once.
//  Loopback: RX input = internal TX serial; external uart_tx held 1; uart_rx ignored.
//  FIFO: simultaneous push+pop -> both happen, level unchanged. A pop frees space for a same-cycle push,
//   so a bus push to a full TX FIFO on the cycle the engine pops is accepted. Bus read of an empty
//   RX FIFO on the cycle a word arrives returns 0; the word is stored. Pointers wrap modulo depth.
//  Sticky set and W1C in the same cycle: set wins.
// TESTING
//  1 CTRL=0x07, BAUD=0, DATA<=0xA5 -> uart_tx low 16 cyc, then bits 1,0,1,0,0,1,0,1 at 16 cyc each, high 16; tx_busy 1->0.
//  2 CTRL=0x47 (loopback), write 0x11,0x22,0x33 -> rx_level 3; DATA reads return 0x11,0x22,0x33; uart_tx stays 1.
//  3 CTRL=0x01, 17 DATA writes -> STATUS tx_full=1, tx_level=16, TX_OVF=1; write 0x80 to STATUS -> TX_OVF=0.
//  4 CTRL=0x1F (odd parity), drive rx 0x5A with parity 0 -> PAR=1, rx_empty=1; IM=4 -> uart_irq=1.
//  5 Drive rx frame with stop=0 -> FRAME=1, FIFO empty. Fill RX with 17 good frames -> RX_OVR=1, rx_level=16.
//  6 Assert wb_rst_ni=0 mid-TX-frame -> next cycle uart_tx=1, tx_level=0, ack=0, irq=0.

Source files
------------

// File: rtl/uart_fifo_wb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_fifo_wb: Wishbone UART with TX/RX FIFOs, 16x baud, parity, IRQ.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+

module uart_fifo_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_pop_done,
  output logic [7:0]       o_level
);
  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == (c_AW+1)'(DEPTH));
  // A pop frees a slot for a push in the same cycle.
  assign w_do_pop   = i_pop & ~o_empty;
  assign w_do_push  = i_push & (~o_full | w_do_pop);
  assign o_dout     = r_mem[r_rd_ptr];
  assign o_pop_done = w_do_pop;
  assign o_level    = 8'(r_count);

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push & ~w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop & ~w_do_push) r_count <= r_count - 1'b1;
    end
  end
endmodule

module uart_fifo_wb #(
  parameter int          DATA_BITS    = 8,
  parameter int          TX_DEPTH     = 16,
  parameter int          RX_DEPTH     = 16,
  parameter logic [15:0] BAUD_DIV_RST = 16'd0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [1:0]  io_oeb,
  output logic        uart_irq
);
  localparam logic [2:0] c_ADR_DATA   = 3'd0;
  localparam logic [2:0] c_ADR_STATUS = 3'd1;
  localparam logic [2:0] c_ADR_CTRL   = 3'd2;
  localparam logic [2:0] c_ADR_BAUD   = 3'd3;
  localparam logic [2:0] c_ADR_IM     = 3'd4;
  localparam logic [2:0] c_ADR_IRQ    = 3'd5;
  localparam logic [3:0] c_LAST_BIT   = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP1, TX_STOP2} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

  logic        r_ack;
  logic [31:0] r_dat;
  logic [6:0]  r_ctrl;
  logic [15:0] r_baud;
  logic [2:0]  r_im;
  logic [3:0]  r_sticky;     // {TX_OVF, PAR, FRAME, RX_OVR}
  logic        r_irq;
  logic [15:0] r_baud_cnt;

  logic        w_req, w_wr, w_rd, w_tick;
  logic [2:0]  w_adr;
  logic        w_en, w_tx_en, w_rx_en, w_par_en, w_par_odd, w_stop2, w_loop;
  logic [31:0] w_rdata, w_status;
  logic [3:0]  w_st_set, w_st_clr;
  logic [2:0]  w_irq_src;
  logic        w_unused;

  logic                 w_tx_push, w_tx_pop, w_tx_popped, w_tx_empty, w_tx_full;
  logic [DATA_BITS-1:0] w_tx_dout;
  logic [7:0]           w_tx_level;
  logic                 w_rx_push, w_rx_pop, w_rx_popped, w_rx_empty, w_rx_full;
  logic [DATA_BITS-1:0] w_rx_dout;
  logic [7:0]           w_rx_level;

  tx_state_t            r_tx_state, w_tx_state_nx;
  logic [3:0]           r_tx_cnt, w_tx_cnt_nx, r_tx_bit, w_tx_bit_nx;
  logic [DATA_BITS-1:0] r_tx_sh, w_tx_sh_nx;
  logic                 r_tx_par, w_tx_par_nx, w_tx_end, w_tx_ser;

  rx_state_t            r_rx_state, w_rx_state_nx;
  logic [3:0]           r_rx_cnt, w_rx_cnt_nx, r_rx_bit, w_rx_bit_nx;
  logic [DATA_BITS-1:0] r_rx_sh, w_rx_sh_nx;
  logic                 r_rx_parbit, w_rx_parbit_nx;
  logic                 r_rx_meta, r_rx_sync, r_rx_prev, w_rx_in;
  logic                 w_frame_err, w_par_err;

  assign w_req     = wbs_stb_i & wbs_cyc_i & ~r_ack;
  assign w_wr      = w_req & wbs_we_i;
  assign w_rd      = w_req & ~wbs_we_i;
  assign w_adr     = wbs_adr_i[4:2];
  assign w_en      = r_ctrl[0];
  assign w_tx_en   = r_ctrl[1];
  assign w_rx_en   = r_ctrl[2];
  assign w_par_en  = r_ctrl[3];
  assign w_par_odd = r_ctrl[4];
  assign w_stop2   = r_ctrl[5];
  assign w_loop    = r_ctrl[6];
  assign w_unused  = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2],
                       w_tx_popped, w_rx_popped};

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign uart_irq  = r_irq;
  assign io_oeb    = 2'b01;
  assign uart_tx   = w_tx_ser | w_loop | ~w_en;

  assign w_tick = w_en & (r_baud_cnt == r_baud);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni || !w_en) r_baud_cnt <= '0;
    else if (w_tick)         r_baud_cnt <= '0;
    else                     r_baud_cnt <= r_baud_cnt + 16'd1;
  end

  assign w_tx_push = w_wr & (w_adr == c_ADR_DATA) & wbs_sel_i[0];
  assign w_rx_pop  = w_rd & (w_adr == c_ADR_DATA) & ~w_rx_empty;

  uart_fifo_wb_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .i_clk(wb_clk_i), .i_rst_n(wb_rst_ni), .i_push(w_tx_push), .i_din(wbs_dat_i[DATA_BITS-1:0]),
    .i_pop(w_tx_pop), .o_dout(w_tx_dout), .o_empty(w_tx_empty), .o_full(w_tx_full),
    .o_pop_done(w_tx_popped), .o_level(w_tx_level)
  );

  uart_fifo_wb_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .i_clk(wb_clk_i), .i_rst_n(wb_rst_ni), .i_push(w_rx_push), .i_din(r_rx_sh),
    .i_pop(w_rx_pop), .o_dout(w_rx_dout), .o_empty(w_rx_empty), .o_full(w_rx_full),
    .o_pop_done(w_rx_popped), .o_level(w_rx_level)
  );

  assign w_tx_end = w_tick & (r_tx_cnt == 4'd15);

  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_cnt_nx   = w_tick ? r_tx_cnt + 4'd1 : r_tx_cnt;
    w_tx_bit_nx   = r_tx_bit;
    w_tx_sh_nx    = r_tx_sh;
    w_tx_par_nx   = r_tx_par;
    w_tx_pop      = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_nx = 4'd0;
        if (w_en & w_tx_en & ~w_tx_empty) begin
          w_tx_pop      = 1'b1;
          w_tx_sh_nx    = w_tx_dout;
          w_tx_par_nx   = (^w_tx_dout) ^ w_par_odd;
          w_tx_bit_nx   = 4'd0;
          w_tx_state_nx = TX_START;
        end
      end
      TX_START: if (w_tx_end) w_tx_state_nx = TX_DATA;
      TX_DATA: begin
        if (w_tx_end) begin
          if (r_tx_bit == c_LAST_BIT) begin
            w_tx_state_nx = w_par_en ? TX_PAR : TX_STOP1;
          end else begin
            w_tx_bit_nx = r_tx_bit + 4'd1;
            w_tx_sh_nx  = r_tx_sh >> 1;
          end
        end
      end
      TX_PAR:   if (w_tx_end) w_tx_state_nx = TX_STOP1;
      TX_STOP1: if (w_tx_end) w_tx_state_nx = w_stop2 ? TX_STOP2 : TX_IDLE;
      TX_STOP2: if (w_tx_end) w_tx_state_nx = TX_IDLE;
      default:  w_tx_state_nx = TX_IDLE;
    endcase
    if (!w_en) begin
      w_tx_state_nx = TX_IDLE;
      w_tx_cnt_nx   = 4'd0;
      w_tx_pop      = 1'b0;
    end
  end

  always_comb begin
    case (r_tx_state)
      TX_START: w_tx_ser = 1'b0;
      TX_DATA:  w_tx_ser = r_tx_sh[0];
      TX_PAR:   w_tx_ser = r_tx_par;
      default:  w_tx_ser = 1'b1;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_sh    <= '0;
      r_tx_par   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_cnt   <= w_tx_cnt_nx;
      r_tx_bit   <= w_tx_bit_nx;
      r_tx_sh    <= w_tx_sh_nx;
      r_tx_par   <= w_tx_par_nx;
    end
  end

  // Loopback feeds the internal serial stream into the receiver.
  assign w_rx_in = w_loop ? w_tx_ser : uart_rx;

  always_comb begin
    w_rx_state_nx  = r_rx_state;
    w_rx_cnt_nx    = w_tick ? r_rx_cnt + 4'd1 : r_rx_cnt;
    w_rx_bit_nx    = r_rx_bit;
    w_rx_sh_nx     = r_rx_sh;
    w_rx_parbit_nx = r_rx_parbit;
    w_rx_push      = 1'b0;
    w_frame_err    = 1'b0;
    w_par_err      = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nx = 4'd0;
        if (r_rx_prev & ~r_rx_sync) w_rx_state_nx = RX_START;
      end
      RX_START: begin
        if (w_tick && r_rx_cnt == 4'd7) begin
          w_rx_cnt_nx   = 4'd0;
          w_rx_bit_nx   = 4'd0;
          w_rx_state_nx = r_rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_tick && r_rx_cnt == 4'd15) begin
          w_rx_sh_nx = {r_rx_sync, r_rx_sh[DATA_BITS-1:1]};
          if (r_rx_bit == c_LAST_BIT) w_rx_state_nx = w_par_en ? RX_PAR : RX_STOP;
          else                        w_rx_bit_nx   = r_rx_bit + 4'd1;
        end
      end
      RX_PAR: begin
        if (w_tick && r_rx_cnt == 4'd15) begin
          w_rx_parbit_nx = r_rx_sync;
          w_rx_state_nx  = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_tick && r_rx_cnt == 4'd15) begin
          w_rx_state_nx = RX_IDLE;
          if (!r_rx_sync) w_frame_err = 1'b1;
          else if (w_par_en && (r_rx_parbit != ((^r_rx_sh) ^ w_par_odd))) w_par_err = 1'b1;
          else w_rx_push = 1'b1;
        end
      end
      default: w_rx_state_nx = RX_IDLE;
    endcase
    if (!w_en || !w_rx_en) begin
      w_rx_state_nx = RX_IDLE;
      w_rx_cnt_nx   = 4'd0;
      w_rx_push     = 1'b0;
      w_frame_err   = 1'b0;
      w_par_err     = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_sh     <= '0;
      r_rx_parbit <= 1'b0;
    end else begin
      r_rx_meta   <= w_rx_in;
      r_rx_sync   <= r_rx_meta;
      r_rx_prev   <= r_rx_sync;
      r_rx_state  <= w_rx_state_nx;
      r_rx_cnt    <= w_rx_cnt_nx;
      r_rx_bit    <= w_rx_bit_nx;
      r_rx_sh     <= w_rx_sh_nx;
      r_rx_parbit <= w_rx_parbit_nx;
    end
  end

  assign w_st_set  = {w_tx_push & w_tx_full & ~w_tx_pop, w_par_err, w_frame_err,
                      w_rx_push & w_rx_full & ~w_rx_pop};
  assign w_st_clr  = (w_wr && w_adr == c_ADR_STATUS) ? wbs_dat_i[7:4] : 4'd0;
  assign w_irq_src = {|r_sticky, w_tx_empty, ~w_rx_empty};
  assign w_status  = {w_tx_level, w_rx_level, 6'd0, r_rx_state != RX_IDLE, r_tx_state != TX_IDLE,
                      r_sticky, w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};

  always_comb begin
    w_rdata = '0;
    case (w_adr)
      c_ADR_DATA:   if (!w_rx_empty) w_rdata[DATA_BITS-1:0] = w_rx_dout;
      c_ADR_STATUS: w_rdata = w_status;
      c_ADR_CTRL:   w_rdata[6:0] = r_ctrl;
      c_ADR_BAUD:   w_rdata[15:0] = r_baud;
      c_ADR_IM:     w_rdata[2:0] = r_im;
      c_ADR_IRQ:    w_rdata[2:0] = w_irq_src;
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_ctrl   <= '0;
      r_baud   <= BAUD_DIV_RST;
      r_im     <= '0;
      r_sticky <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rdata : 32'd0;
      if (w_wr && w_adr == c_ADR_CTRL && wbs_sel_i[0]) r_ctrl <= wbs_dat_i[6:0];
      if (w_wr && w_adr == c_ADR_BAUD) begin
        if (wbs_sel_i[0]) r_baud[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) r_baud[15:8] <= wbs_dat_i[15:8];
      end
      if (w_wr && w_adr == c_ADR_IM && wbs_sel_i[0]) r_im <= wbs_dat_i[2:0];
      // A new error in the same cycle as its clear is kept.
      r_sticky <= (r_sticky & ~w_st_clr) | w_st_set;
      r_irq    <= |(r_im & w_irq_src);
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_wb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_fifo_wb: scoreboard bench for the Wishbone UART. Rev 1.0            |
// +----------------------------------------------------------------------------+
module tb_uart_fifo_wb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] dat_i = '0, adr = '0;
  logic        ack, tx, irq;
  logic [31:0] dat_o;
  logic        rx = 1'b1;
  logic [1:0]  oeb;

  always #5 clk = ~clk;

  uart_fifo_wb #(.DATA_BITS(8), .TX_DEPTH(16), .RX_DEPTH(16), .BAUD_DIV_RST(16'd0)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .uart_rx(rx), .uart_tx(tx), .io_oeb(oeb), .uart_irq(irq)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_pending = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every read acknowledge is matched against the oldest expectation.
  always @(negedge clk) begin
    if (ack && rd_pending) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read_ack: got 0x%08h, expected no read", dat_o);
      end else begin
        automatic string       nm = name_q.pop_front();
        automatic logic [31:0] ex = exp_q.pop_front();
        check(nm, dat_o, ex);
      end
    end
  end

  task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    automatic bit got = 1'b0;
    @(negedge clk);
    rd_pending = ~w;
    stb = 1'b1; cyc = 1'b1; we = w; adr = {27'd0, a, 2'b00}; dat_i = d; sel = s;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ack) got = 1'b1;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL bus_ack_timeout: got no ack in 8 cycles, expected ack");
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    bus(1'b1, a, d, s);
  endtask

  task automatic rd(input string nm, input logic [2:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    bus(1'b0, a, 32'd0, 4'hF);
  endtask

  task automatic send_rx(input logic [7:0] b, input bit has_par, input logic p, input logic stop);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    if (has_par) begin
      rx = p;
      repeat (16) @(negedge clk);
    end
    rx = stop;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_tx_low(input string nm);
    automatic bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (tx === 1'b0) found = 1'b1;
    end
    check(nm, {31'd0, found}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    automatic int          n;
    automatic logic [7:0]  bits;
    automatic logic        stopb;
    automatic bit          hi;

    repeat (4) @(negedge clk);
    check("rst_uart_tx", {31'd0, tx}, 32'd1);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat_o", dat_o, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("io_oeb", {30'd0, oeb}, 32'd1);
    rst_n = 1'b1;
    rd("rst_status", 3'd1, 32'h0000_0005);
    rd("rst_ctrl", 3'd2, 32'd0);

    // Plain transmit of 0xA5 at divisor 0.
    wr(3'd2, 32'h07);
    wr(3'd3, 32'h0);
    wr(3'd0, 32'hA5);
    wait_tx_low("tx_start_seen");
    n = 0;
    while (tx === 1'b0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("tx_start_len", n, 32'd16);
    for (int i = 0; i < 8; i++) begin
      repeat (8) @(negedge clk);
      bits[i] = tx;
      repeat (8) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    stopb = tx;
    check("tx_data_bits", {24'd0, bits}, 32'hA5);
    check("tx_stop_bit", {31'd0, stopb}, 32'd1);
    repeat (20) @(negedge clk);
    wr(3'd0, 32'h3C);
    rd("tx_busy_status", 3'd1, 32'h0000_0105);
    repeat (200) @(negedge clk);
    rd("tx_done_status", 3'd1, 32'h0000_0005);

    // Loopback.
    wr(3'd2, 32'h47);
    wr(3'd0, 32'h11);
    wr(3'd0, 32'h22);
    wr(3'd0, 32'h33);
    hi = 1'b1;
    repeat (600) begin
      @(negedge clk);
      if (tx !== 1'b1) hi = 1'b0;
    end
    check("loop_tx_held_high", {31'd0, hi}, 32'd1);
    rd("loop_status", 3'd1, 32'h0003_0001);
    rd("loop_data0", 3'd0, 32'h11);
    rd("loop_data1", 3'd0, 32'h22);
    rd("loop_data2", 3'd0, 32'h33);
    rd("rx_empty_read", 3'd0, 32'h0);

    // TX FIFO overflow with transmitter disabled.
    wr(3'd2, 32'h01);
    for (int i = 0; i < 17; i++) wr(3'd0, 32'(i));
    rd("tx_full_status", 3'd1, 32'h1000_0086);
    wr(3'd1, 32'h80);
    rd("tx_ovf_cleared", 3'd1, 32'h1000_0006);
    wr(3'd2, 32'h03);
    repeat (2700) @(negedge clk);
    rd("tx_drained", 3'd1, 32'h0000_0005);

    // Odd parity error, then IRQ masking.
    wr(3'd2, 32'h1F);
    send_rx(8'h5A, 1'b1, 1'b0, 1'b1);
    rd("par_status", 3'd1, 32'h0000_0045);
    check("irq_masked", {31'd0, irq}, 32'd0);
    wr(3'd4, 32'h4);
    repeat (3) @(negedge clk);
    check("irq_par", {31'd0, irq}, 32'd1);
    rd("irq_reg", 3'd5, 32'h6);
    wr(3'd1, 32'h40);
    repeat (3) @(negedge clk);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    send_rx(8'h5A, 1'b1, 1'b1, 1'b1);
    rd("par_good_data", 3'd0, 32'h5A);

    // Framing error, then RX overrun.
    wr(3'd2, 32'h07);
    send_rx(8'h33, 1'b0, 1'b0, 1'b0);
    rd("frame_status", 3'd1, 32'h0000_0025);
    wr(3'd1, 32'h20);
    for (int i = 1; i <= 17; i++) send_rx(8'(i), 1'b0, 1'b0, 1'b1);
    rd("rx_ovr_status", 3'd1, 32'h0010_0019);
    rd("rx_first_word", 3'd0, 32'h01);

    // Reset in the middle of a frame.
    wr(3'd4, 32'h2);
    wr(3'd0, 32'h55);
    wait_tx_low("rst_frame_started");
    repeat (5) @(negedge clk);
    check("irq_tx_empty", {31'd0, irq}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_uart_tx", {31'd0, tx}, 32'd1);
    check("midrst_ack", {31'd0, ack}, 32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    rd("midrst_status", 3'd1, 32'h0000_0005);
    rd("midrst_ctrl", 3'd2, 32'd0);
    rd("midrst_im", 3'd4, 32'd0);

    // Byte-lane writes and unmapped address.
    wr(3'd3, 32'h0000_1234, 4'b0001);
    rd("baud_lane0", 3'd3, 32'h0000_0034);
    wr(3'd3, 32'h0000_AB00, 4'b0010);
    rd("baud_lane1", 3'd3, 32'h0000_AB34);
    rd("unmapped_read", 3'd6, 32'd0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
